opc_mem_arbiter: RTL
====================

Name: opc_mem_arbiter

Overview:
Shares one single-port synchronous RAM between the OPC CPU core and a host load/debug port. The CPU is stalled through a clock-enable (cpu_ce) until its access completes. The host uses a valid/ready handshake. The block sits between the CPU's address/data/rnw pins, the host interface and the on-chip RAM macro. A saturating counter of CPU stall cycles is provided for performance checks.

Parameters:
AW, 11, address width (CPU and host)
DW, 8, data width
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_run  in  1  CPU may be granted; 0 = CPU frozen (debug halt / boot load)
cpu_addr  in  AW  CPU access address
cpu_rnw  in  1  1 = read, 0 = write
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data
cpu_ce  out  1  one-cycle pulse; CPU advances its state on clk when high
host_valid  in  1  host request pending; held with fields stable until host_ready
host_we  in  1  host write
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_ready  out  1  one-cycle completion pulse
host_rdata  out  DW  host read data
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered, only with mem_en)
mem_addr  out  AW  RAM address (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid the cycle after mem_en
stall_cnt  out  CNTW  saturating CPU stall count
stat_clr  in  1  clears stall_cnt

Behaviour:
- Reset (clk edge with rst=1) sets state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ce=0, host_ready=0, cpu_rdata/host_rdata hold registers=0, stall_cnt=0 and last_owner=HOST, so the CPU wins the first tie.
- FSM states: IDLE, ISSUE, COMPLETE. A slot is ISSUE followed by COMPLETE, with owner CPU or HOST.
- Arbitration happens in IDLE and COMPLETE. The winner's addr/we/wdata and mem_en=1 are registered and the next state is ISSUE. With no eligible requester the next state is IDLE and mem_en=0.
- CPU eligible: cpu_run=1, and the cycle is not the COMPLETE of a CPU slot (the CPU address is stale there).
- Host eligible: host_valid=1, and the cycle is not the COMPLETE of a host slot.
- Both eligible: the winner is the requester that is not last_owner (round-robin). last_owner updates on each grant.
- ISSUE: mem_en/mem_we are high for exactly this cycle and the RAM samples them. Next state is COMPLETE. mem_en and mem_we drop unless a new grant is registered in COMPLETE.
- COMPLETE: the owner's strobe (cpu_ce or host_ready) is high for exactly this cycle, for reads and writes alike.
  - cpu_rdata = mem_rdata when owner=CPU in COMPLETE, otherwise the captured register. host_rdata follows the same rule.
  - Each capture register loads mem_rdata at the end of its owner's COMPLETE.
- Latency: from an IDLE grant cycle t, ISSUE is t+1 and the strobe is t+2. A lone CPU gets one access every 3 cycles. With both requesting continuously, slots alternate C,H,C,H and there is one strobe every 2 cycles.
- mem_we=1 never occurs with mem_en=0. mem_wdata is don't-care on reads but is registered anyway.
- cpu_run falling while a CPU slot is in flight: the slot completes and cpu_ce still pulses.
- host_valid dropping before host_ready is illegal; the bench flags it.
- stall_cnt increments each cycle with cpu_run=1 and cpu_ce=0, saturates at 2^CNTW-1 and is cleared by stat_clr. If stat_clr and an increment occur together, the result is 0.
- rst mid-slot: the slot is abandoned. The next cycle has mem_en=0 and no strobe, and the host must re-present its request.

Test Plan:
- Reset then cpu_run=1, cpu_addr=0x100, cpu_rnw=1, RAM[0x100]=0x5A -> mem_en=1/mem_addr=0x100 at t0+1, cpu_ce=1 with cpu_rdata=0x5A at t0+2, next mem_en at t0+4.
- CPU write: cpu_rnw=0, addr 0x020, wdata 0x3C -> single cycle mem_en=mem_we=1, mem_addr=0x020, mem_wdata=0x3C; cpu_ce pulses once; RAM[0x020]=0x3C.
- cpu_run=0, host writes 0x7FF=0xA5 then reads 0x7FF -> host_ready once per request, host_rdata=0xA5; cpu_ce stays 0; stall_cnt stays 0.
- Contention: cpu_run=1 and host_valid held continuously over 20 cycles -> first grant CPU, then strict alternation, strobes every 2 cycles, 5 cpu_ce and 5 host_ready.
- rst pulsed during ISSUE of a host write -> the following cycle has mem_en=0 and no host_ready; the re-issued request completes normally.
- CNTW=4, cpu_run=1 with host saturating the alternate slots -> stall_cnt climbs to 15 and holds; stat_clr -> 0 the next cycle.

Source files
------------

// File: rtl/opc_mem_arbiter_if.sv
// Host load/debug port: valid/ready request channel into the OPC memory arbiter.
// The host drives the request fields; the arbiter returns a completion pulse and read data.
interface opc_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic [DW-1:0] host_rdata;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata
  );
endinterface

// File: rtl/opc_mem_arbiter.sv
// Round-robin sharing of one synchronous single-port RAM between the OPC CPU (stalled via
// cpu_ce) and a host port. Each slot is ISSUE then COMPLETE; a stall-cycle counter is kept.
module opc_mem_arbiter #(
  parameter int AW   = 11,
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_run,
  input  logic [AW-1:0]   cpu_addr,
  input  logic            cpu_rnw,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_ce,
  opc_mem_arbiter_if.slave host,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [CNTW-1:0] stall_cnt,
  input  logic            stat_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  state_t        state;
  owner_t        owner;
  owner_t        last_owner;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] host_rdata_q;

  logic cpu_elig;
  logic host_elig;
  logic grant_cpu;
  logic grant_host;

  // A requester whose slot is completing this cycle is not eligible: its request is stale.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cpu_elig   = 1'b0;
    host_elig  = 1'b0;
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (state == IDLE || state == COMPLETE) begin
      cpu_elig   = cpu_run && !(state == COMPLETE && owner == OWN_CPU);
      host_elig  = host.host_valid && !(state == COMPLETE && owner == OWN_HOST);
      grant_cpu  = cpu_elig && (!host_elig || last_owner == OWN_HOST);
      grant_host = host_elig && !grant_cpu;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_HOST;
      last_owner   <= OWN_HOST;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_ce       <= 1'b0;
      host.host_ready <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_ce          <= 1'b0;
      host.host_ready <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      case (state)
        IDLE, COMPLETE: begin
          if (state == COMPLETE) begin
            if (owner == OWN_CPU) cpu_rdata_q  <= mem_rdata;
            else                  host_rdata_q <= mem_rdata;
          end
          if (grant_cpu) begin
            state      <= ISSUE;
            owner      <= OWN_CPU;
            last_owner <= OWN_CPU;
            mem_en     <= 1'b1;
            mem_we     <= !cpu_rnw;
            mem_addr   <= cpu_addr;
            mem_wdata  <= cpu_wdata;
          end else if (grant_host) begin
            state      <= ISSUE;
            owner      <= OWN_HOST;
            last_owner <= OWN_HOST;
            mem_en     <= 1'b1;
            mem_we     <= host.host_we;
            mem_addr   <= host.host_addr;
            mem_wdata  <= host.host_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state           <= COMPLETE;
          cpu_ce          <= (owner == OWN_CPU);
          host.host_ready <= (owner == OWN_HOST);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stall_cnt <= '0;
    end else if (cpu_run && !cpu_ce && stall_cnt != {CNTW{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign cpu_rdata       = (state == COMPLETE && owner == OWN_CPU)  ? mem_rdata : cpu_rdata_q;
  assign host.host_rdata = (state == COMPLETE && owner == OWN_HOST) ? mem_rdata : host_rdata_q;

endmodule
